// File: rtl/uvma_rvfi_pkg.sv
// Shared types for the RVFI retirement checker: compare record, mask-bit
// positions, checker state and the field-compare helper.
package uvma_rvfi_pkg;

  // Width-independent storage: narrower XLEN values are zero-extended on entry.
  localparam int unsigned CMP_XLEN = 64;
  localparam int unsigned MASK_W   = 6;

  localparam int unsigned MASK_ORDER    = 0;
  localparam int unsigned MASK_PC       = 1;
  localparam int unsigned MASK_INSN     = 2;
  localparam int unsigned MASK_TRAP     = 3;
  localparam int unsigned MASK_RD_ADDR  = 4;
  localparam int unsigned MASK_RD_WDATA = 5;

  typedef struct packed {
    logic [63:0]         order;
    logic [CMP_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic                trap;
    logic [4:0]          rd_addr;
    logic [CMP_XLEN-1:0] rd_wdata;
  } st_rvfi_cmp;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } e_cmp_state;

  // Writes to x0 are architecturally discarded, so their data is not compared.
  function automatic logic [MASK_W-1:0] cmp_mask(input st_rvfi_cmp dut,
                                                 input st_rvfi_cmp rm);
    logic [MASK_W-1:0] m;
    m                = '0;
    m[MASK_ORDER]    = (dut.order   != rm.order);
    m[MASK_PC]       = (dut.pc      != rm.pc);
    m[MASK_INSN]     = (dut.insn    != rm.insn);
    m[MASK_TRAP]     = (dut.trap    != rm.trap);
    m[MASK_RD_ADDR]  = (dut.rd_addr != rm.rd_addr);
    m[MASK_RD_WDATA] = (dut.rd_addr != 5'd0) && (dut.rd_wdata != rm.rd_wdata);
    return m;
  endfunction

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// Synchronous FIFO of compare records; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module rvfi_cmp_fifo
  import uvma_rvfi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  st_rvfi_cmp               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output st_rvfi_cmp               head
);

  localparam int unsigned AW = $clog2(DEPTH);

  st_rvfi_cmp    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // When full, a push is accepted only alongside a pop that frees the head slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the cleared pointers alone make every stale slot unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rvfi_retire_compare.sv
// Lock-step retirement checker: queues DUT retirements, compares each against
// the reference result for the same instruction and freezes on the first error.
module rvfi_retire_compare
  import uvma_rvfi_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dut_valid_i,
  input  logic [63:0]              dut_order_i,
  input  logic [XLEN-1:0]          dut_pc_i,
  input  logic [31:0]              dut_insn_i,
  input  logic                     dut_trap_i,
  input  logic [4:0]               dut_rd_addr_i,
  input  logic [XLEN-1:0]          dut_rd_wdata_i,
  input  logic                     ref_valid_i,
  input  logic [63:0]              ref_order_i,
  input  logic [XLEN-1:0]          ref_pc_i,
  input  logic [31:0]              ref_insn_i,
  input  logic                     ref_trap_i,
  input  logic [4:0]               ref_rd_addr_i,
  input  logic [XLEN-1:0]          ref_rd_wdata_i,
  output logic                     mismatch_o,
  output logic [5:0]               mismatch_mask_o,
  output logic [63:0]              mismatch_order_o,
  output logic                     overflow_o,
  output logic                     orphan_o,
  output logic                     halted_o,
  output logic [31:0]              match_count_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  e_cmp_state        state;
  st_rvfi_cmp        dut_entry;
  st_rvfi_cmp        rm_entry;
  st_rvfi_cmp        head;
  st_rvfi_cmp        cmp_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              bypass;
  logic              cmp_valid;
  logic              overflow_ev;
  logic              orphan_ev;
  logic [MASK_W-1:0] mask;

  always_comb begin
    dut_entry.order    = dut_order_i;
    dut_entry.pc       = CMP_XLEN'(dut_pc_i);
    dut_entry.insn     = dut_insn_i;
    dut_entry.trap     = dut_trap_i;
    dut_entry.rd_addr  = dut_rd_addr_i;
    dut_entry.rd_wdata = CMP_XLEN'(dut_rd_wdata_i);
    rm_entry.order     = ref_order_i;
    rm_entry.pc        = CMP_XLEN'(ref_pc_i);
    rm_entry.insn      = ref_insn_i;
    rm_entry.trap      = ref_trap_i;
    rm_entry.rd_addr   = ref_rd_addr_i;
    rm_entry.rd_wdata  = CMP_XLEN'(ref_rd_wdata_i);
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    bypass      = 1'b0;
    fifo_pop    = 1'b0;
    fifo_push   = 1'b0;
    overflow_ev = 1'b0;
    orphan_ev   = 1'b0;
    cmp_valid   = 1'b0;
    if (state == ST_RUN) begin
      bypass      = fifo_empty && dut_valid_i && ref_valid_i;
      fifo_pop    = ref_valid_i && !fifo_empty;
      fifo_push   = dut_valid_i && !bypass && (!fifo_full || fifo_pop);
      overflow_ev = dut_valid_i && fifo_full && !fifo_pop;
      orphan_ev   = ref_valid_i && fifo_empty && !dut_valid_i;
      cmp_valid   = bypass || fifo_pop;
    end
    cmp_entry = bypass ? dut_entry : head;
    mask      = cmp_mask(cmp_entry, rm_entry);
  end

  rvfi_cmp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dut_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o),
    .head  (head)
  );

  // NOTE: state and outputs use <= so every read in this block sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_RUN;
      mismatch_o       <= 1'b0;
      mismatch_mask_o  <= '0;
      mismatch_order_o <= '0;
      overflow_o       <= 1'b0;
      orphan_o         <= 1'b0;
      halted_o         <= 1'b0;
      match_count_o    <= '0;
    end else if (state == ST_RUN) begin
      if (cmp_valid && (mask == '0)) begin
        match_count_o <= match_count_o + 32'd1;
      end
      if (cmp_valid && (mask != '0)) begin
        mismatch_o       <= 1'b1;
        mismatch_mask_o  <= mask;
        mismatch_order_o <= cmp_entry.order;
      end
      if (overflow_ev) overflow_o <= 1'b1;
      if (orphan_ev)   orphan_o   <= 1'b1;
      if ((cmp_valid && (mask != '0)) || overflow_ev || orphan_ev) begin
        state    <= ST_HALT;
        halted_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_retire_compare.sv
// Directed bench for rvfi_retire_compare with hand-computed expectations.
module tb_rvfi_retire_compare;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dut_valid_i, ref_valid_i;
  logic [63:0] dut_order_i, ref_order_i;
  logic [31:0] dut_pc_i, ref_pc_i, dut_insn_i, ref_insn_i;
  logic        dut_trap_i, ref_trap_i;
  logic [4:0]  dut_rd_addr_i, ref_rd_addr_i;
  logic [31:0] dut_rd_wdata_i, ref_rd_wdata_i;
  logic        mismatch_o, overflow_o, orphan_o, halted_o;
  logic [5:0]  mismatch_mask_o;
  logic [63:0] mismatch_order_o;
  logic [31:0] match_count_o;
  logic [3:0]  level_o;

  int n_cmp  = 0;
  int n_fail = 0;

  rvfi_retire_compare #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dut_valid_i(dut_valid_i), .dut_order_i(dut_order_i), .dut_pc_i(dut_pc_i),
    .dut_insn_i(dut_insn_i), .dut_trap_i(dut_trap_i), .dut_rd_addr_i(dut_rd_addr_i),
    .dut_rd_wdata_i(dut_rd_wdata_i),
    .ref_valid_i(ref_valid_i), .ref_order_i(ref_order_i), .ref_pc_i(ref_pc_i),
    .ref_insn_i(ref_insn_i), .ref_trap_i(ref_trap_i), .ref_rd_addr_i(ref_rd_addr_i),
    .ref_rd_wdata_i(ref_rd_wdata_i),
    .mismatch_o(mismatch_o), .mismatch_mask_o(mismatch_mask_o),
    .mismatch_order_o(mismatch_order_o), .overflow_o(overflow_o), .orphan_o(orphan_o),
    .halted_o(halted_o), .match_count_o(match_count_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dut_valid_i = 1'b0;
    ref_valid_i = 1'b0;
  endtask

  task automatic drive_dut(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] insn,
                           input logic trap, input logic [4:0] rd, input logic [31:0] wd);
    dut_valid_i = 1'b1; dut_order_i = order; dut_pc_i = pc; dut_insn_i = insn;
    dut_trap_i = trap; dut_rd_addr_i = rd; dut_rd_wdata_i = wd;
  endtask

  task automatic drive_ref(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] insn,
                           input logic trap, input logic [4:0] rd, input logic [31:0] wd);
    ref_valid_i = 1'b1; ref_order_i = order; ref_pc_i = pc; ref_insn_i = insn;
    ref_trap_i = trap; ref_rd_addr_i = rd; ref_rd_wdata_i = wd;
  endtask

  // Instruction i of a synthetic stream; identical on both sides so it always matches.
  task automatic stream_dut(input int i);
    drive_dut(64'(i), 32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 1'b0, 5'(i), 32'(3 * i));
  endtask

  task automatic stream_ref(input int i);
    drive_ref(64'(i), 32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 1'b0, 5'(i), 32'(3 * i));
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    check({tag, ".mismatch"}, 64'(mismatch_o), 64'd0);
    check({tag, ".mask"},     64'(mismatch_mask_o), 64'd0);
    check({tag, ".order"},    mismatch_order_o, 64'd0);
    check({tag, ".overflow"}, 64'(overflow_o), 64'd0);
    check({tag, ".orphan"},   64'(orphan_o), 64'd0);
    check({tag, ".halted"},   64'(halted_o), 64'd0);
    check({tag, ".count"},    64'(match_count_o), 64'd0);
    check({tag, ".level"},    64'(level_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    drive_dut(64'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_ref(64'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    step();
    step();
    rst_i = 1'b0;
    check_clear("reset");

    // Bypass match: both sides in the same cycle with an empty FIFO.
    drive_dut(64'd1, 32'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
    drive_ref(64'd1, 32'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
    step();
    idle();
    check("bypass.count", 64'(match_count_o), 64'd1);
    check("bypass.level", 64'(level_o), 64'd0);
    check("bypass.mismatch", 64'(mismatch_o), 64'd0);
    check("bypass.orphan", 64'(orphan_o), 64'd0);
    check("bypass.halted", 64'(halted_o), 64'd0);

    // Lagged stream: fill to DEPTH, then drain.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      stream_dut(i);
      step();
      if (i == 4) check("lag.level4", 64'(level_o), 64'd4);
    end
    idle();
    check("lag.level_peak", 64'(level_o), 64'd8);
    check("lag.no_overflow", 64'(overflow_o), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      stream_ref(i);
      step();
    end
    idle();
    check("lag.count", 64'(match_count_o), 64'd8);
    check("lag.level_end", 64'(level_o), 64'd0);
    check("lag.mismatch", 64'(mismatch_o), 64'd0);
    check("lag.overflow", 64'(overflow_o), 64'd0);

    // Full FIFO with simultaneous push and pop is legal.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      stream_dut(i);
      step();
    end
    stream_dut(9);
    stream_ref(1);
    step();
    idle();
    check("fullpp.level", 64'(level_o), 64'd8);
    check("fullpp.count", 64'(match_count_o), 64'd1);
    check("fullpp.overflow", 64'(overflow_o), 64'd0);
    for (int i = 2; i <= 9; i++) begin
      stream_ref(i);
      step();
    end
    idle();
    check("fullpp.count_end", 64'(match_count_o), 64'd9);
    check("fullpp.level_end", 64'(level_o), 64'd0);
    check("fullpp.halted", 64'(halted_o), 64'd0);

    // x0 writes: differing wdata is ignored on both bypass and FIFO paths.
    do_reset();
    drive_dut(64'd1, 32'h100, 32'h13, 1'b0, 5'd0, 32'hDEAD);
    drive_ref(64'd1, 32'h100, 32'h13, 1'b0, 5'd0, 32'hBEEF);
    step();
    idle();
    drive_dut(64'd2, 32'h104, 32'h13, 1'b0, 5'd0, 32'hDEAD);
    step();
    idle();
    drive_ref(64'd2, 32'h104, 32'h13, 1'b0, 5'd0, 32'hBEEF);
    step();
    idle();
    check("x0.count", 64'(match_count_o), 64'd2);
    check("x0.mismatch", 64'(mismatch_o), 64'd0);

    // rd_wdata mismatch after one good compare, then HALT must freeze everything.
    do_reset();
    drive_dut(64'd4, 32'h200, 32'h13, 1'b0, 5'd3, 32'h7);
    step();
    drive_dut(64'd5, 32'h204, 32'h13, 1'b0, 5'd3, 32'h1);
    step();
    idle();
    check("wd.level2", 64'(level_o), 64'd2);
    drive_ref(64'd4, 32'h200, 32'h13, 1'b0, 5'd3, 32'h7);
    step();
    drive_ref(64'd5, 32'h204, 32'h13, 1'b0, 5'd3, 32'h2);
    step();
    idle();
    check("wd.mismatch", 64'(mismatch_o), 64'd1);
    check("wd.mask", 64'(mismatch_mask_o), 64'b100000);
    check("wd.order", mismatch_order_o, 64'd5);
    check("wd.halted", 64'(halted_o), 64'd1);
    check("wd.count", 64'(match_count_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_dut(64'(20 + i), 32'h300, 32'h33, 1'b1, 5'd7, 32'h9);
      drive_ref(64'(40 + i), 32'h304, 32'h13, 1'b0, 5'd8, 32'hA);
      step();
    end
    idle();
    check("halt.mask", 64'(mismatch_mask_o), 64'b100000);
    check("halt.order", mismatch_order_o, 64'd5);
    check("halt.count", 64'(match_count_o), 64'd1);
    check("halt.level", 64'(level_o), 64'd0);
    check("halt.overflow", 64'(overflow_o), 64'd0);
    check("halt.orphan", 64'(orphan_o), 64'd0);

    // Multi-field mismatch on the bypass path: order, pc and trap differ.
    do_reset();
    drive_dut(64'd7, 32'h400, 32'h13, 1'b0, 5'd1, 32'h5);
    drive_ref(64'd8, 32'h404, 32'h13, 1'b1, 5'd1, 32'h5);
    step();
    idle();
    check("multi.mask", 64'(mismatch_mask_o), 64'b001011);
    check("multi.order", mismatch_order_o, 64'd7);
    check("multi.count", 64'(match_count_o), 64'd0);

    // Overflow: ninth retirement with no reference result.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      stream_dut(i);
      step();
      if (i == 8) begin
        check("ovf.pre_flag", 64'(overflow_o), 64'd0);
        check("ovf.pre_halt", 64'(halted_o), 64'd0);
      end
    end
    idle();
    check("ovf.flag", 64'(overflow_o), 64'd1);
    check("ovf.level", 64'(level_o), 64'd8);
    check("ovf.halted", 64'(halted_o), 64'd1);
    check("ovf.mismatch", 64'(mismatch_o), 64'd0);
    stream_ref(1);
    step();
    idle();
    check("ovf.hold_level", 64'(level_o), 64'd8);
    check("ovf.hold_count", 64'(match_count_o), 64'd0);

    // Orphan, then a one-cycle reset and a fresh bypass match.
    do_reset();
    drive_ref(64'd1, 32'h8000_0000, 32'h13, 1'b0, 5'd0, 32'd0);
    step();
    idle();
    check("orphan.flag", 64'(orphan_o), 64'd1);
    check("orphan.halted", 64'(halted_o), 64'd1);
    check("orphan.overflow", 64'(overflow_o), 64'd0);
    check("orphan.mismatch", 64'(mismatch_o), 64'd0);
    do_reset();
    check_clear("orphan_rst");
    drive_dut(64'd1, 32'h8000_0000, 32'h13, 1'b0, 5'd0, 32'd0);
    drive_ref(64'd1, 32'h8000_0000, 32'h13, 1'b0, 5'd0, 32'd0);
    step();
    idle();
    check("orphan_rst.count", 64'(match_count_o), 64'd1);

    // Mid-stream reset discards queued entries and ignores same-cycle inputs.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      stream_dut(i);
      step();
    end
    rst_i = 1'b1;
    stream_dut(4);
    drive_ref(64'd99, 32'h0, 32'h0, 1'b1, 5'd2, 32'h0);
    step();
    rst_i = 1'b0;
    idle();
    check_clear("midrst");
    stream_ref(1);
    step();
    idle();
    check("midrst.orphan", 64'(orphan_o), 64'd1);
    check("midrst.count", 64'(match_count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_compare.md
# rvfi_retire_compare

Downstream checker for the Spike-based reference-model shell. Buffers each DUT retirement in a FIFO, waits for the reference model's result for the same instruction, compares selected RVFI fields, and reports the first divergence. It sits in the testbench top between the DUT RVFI monitor tap and the reference-model output, and is non-intrusive: it has no backpressure.

## Interface
Parameters:
- XLEN, 32, data/PC width.
- DEPTH, 8, DUT-entry FIFO depth; must be a power of 2 and at least 2.

Ports (clock is `clk_i`; reset is `rst_i`, synchronous, active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- dut_valid_i  in  1  DUT retired one instruction this cycle.
- dut_order_i / ref_order_i  in  64  rvfi_order.
- dut_pc_i / ref_pc_i  in  XLEN  rvfi_pc_rdata.
- dut_insn_i / ref_insn_i  in  32  rvfi_insn.
- dut_trap_i / ref_trap_i  in  1  rvfi_trap.
- dut_rd_addr_i / ref_rd_addr_i  in  5  rvfi_rd1_addr.
- dut_rd_wdata_i / ref_rd_wdata_i  in  XLEN  rvfi_rd1_wdata.
- ref_valid_i  in  1  a reference result is present this cycle.
- mismatch_o  out  1  sticky; set on the first field mismatch.
- mismatch_mask_o  out  6  fields that differed in the first mismatch.
- mismatch_order_o  out  64  DUT order of the first mismatching entry.
- overflow_o  out  1  sticky; a DUT entry arrived while the FIFO was full.
- orphan_o  out  1  sticky; a reference result arrived with no DUT entry available.
- halted_o  out  1  checker is in HALT.
- match_count_o  out  32  count of successful compares; wraps.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM has two states, RUN and HALT. Reset enters RUN.
- RUN, DUT side: if `dut_valid_i` is high, push the DUT fields.
- RUN, reference side: if `ref_valid_i` is high, compare against the FIFO head and pop it.
- Bypass: if the FIFO is empty and `dut_valid_i` and `ref_valid_i` are high in the same cycle, compare directly against the DUT inputs. Nothing is pushed.
- Simultaneous push and pop when the FIFO is non-empty: both happen and the level is unchanged. A push when full together with a pop is legal.
- Mask bits: [0] order, [1] pc, [2] insn, [3] trap, [4] rd_addr, [5] rd_wdata.
- rd_wdata is compared only when the DUT rd_addr is non-zero; otherwise bit 5 is 0.
- All-zero mask: increment `match_count_o` (modulo 2^32).
- Non-zero mask: latch the mask and the DUT order, set `mismatch_o`, and go to HALT.
- Overflow: `dut_valid_i` with the FIFO full and no pop that cycle. Drop the entry, set `overflow_o`, go to HALT.
- Orphan: `ref_valid_i` with the FIFO empty and no bypass. Set `orphan_o`, go to HALT.
- If several error events occur in one cycle, all corresponding flags are set.
- HALT: no pushes, pops, compares or counter updates. All outputs hold. Only reset leaves HALT.

## Timing
- Reset values: every flag 0, `mismatch_mask_o`=0, `mismatch_order_o`=0, `match_count_o`=0, `level_o`=0, `halted_o`=0. The FIFO pointers are cleared; FIFO contents are not reset.
- Compare is combinational off the FIFO head or the bypass path. All results are registered, so they appear 1 cycle after the `ref_valid_i` edge.
- `halted_o` rises in the same cycle as the causing flag.
- `level_o` updates 1 cycle after a push or pop.
- A reference result may lag its DUT retirement by up to DEPTH cycles of retirements with no loss.
- Reset asserted mid-operation: takes effect at the next edge. All in-flight entries are discarded and inputs sampled in that cycle are ignored.

## Structure
- Add to `uvma_rvfi_pkg`:
  - a `st_rvfi_cmp` packed struct: order, pc, insn, trap, rd_addr, rd_wdata;
  - the six mask-bit index localparams;
  - the RUN/HALT state enum.
- One sub-module, `rvfi_cmp_fifo`: synchronous FIFO of `st_rvfi_cmp`.
  - Ports: push, pop, full, empty, level, head.
  - Simultaneous push and pop is legal when full.
  - Pointers carry an extra wrap bit.

## Test plan
- Bypass match: same cycle, DUT and reference both order=1, pc=0x80000000, insn=0x00000013, rd_addr=0 -> `match_count_o`=1 next cycle, `level_o`=0, no flags.
- Lagged stream: 8 DUT retirements (orders 1–8) on consecutive cycles, then 8 matching reference results -> `level_o` peaks at 8 and returns to 0; `match_count_o`=8; no overflow.
- rd_wdata mismatch: order=5, rd_addr=3, DUT wdata=0x1 vs reference 0x2 -> `mismatch_o`=1, mask=6'b100000, `mismatch_order_o`=5, `halted_o`=1; later traffic does not change any output.
- rd_addr=0 masking: rd_addr=0 with wdata 0xDEAD vs 0xBEEF -> counted as a match.
- Overflow: DEPTH=8, 9 DUT retirements with no reference results -> `overflow_o`=1 on the 9th, `level_o`=8, HALT.
- Orphan and reset: reference result with the FIFO empty -> `orphan_o`=1. Then assert `rst_i` for 1 cycle -> all outputs 0, RUN, and a subsequent bypass match counts 1.
